// File: rtl/event_encoder8_3_pkg.sv
// event_encoder8_3_pkg: shared constants, FSM state type and code helpers for the event encoder
package event_encoder8_3_pkg;
  localparam int N_REQ = 8;
  localparam int CODE_W = 3;
  typedef enum logic {IDLE, PRESENT} state_e;
  function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] c);
    return N_REQ'(1) << c;
  endfunction
  // decoder3_8 numbers its outputs o_1..o_8 with code c landing on o_(8-c)
  function automatic logic [3:0] dec_out_idx(input logic [CODE_W-1:0] c);
    return 4'd8 - {1'b0, c};
  endfunction
endpackage

// File: rtl/event_encoder8_3_pri_enc8_3.sv
// pri_enc8_3: combinational 8-to-3 priority encoder, highest or lowest set bit wins
module pri_enc8_3
  import event_encoder8_3_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic [N_REQ-1:0]  in_i,
  output logic [CODE_W-1:0] code_o,
  output logic              any_o
);
  // the last match in scan order wins, so the scan direction sets the priority
  always_comb begin
    code_o = '0;
    for (int i = 0; i < N_REQ; i++)
      if (in_i[PRIORITY_HIGH ? i : N_REQ-1-i]) code_o = CODE_W'(PRIORITY_HIGH ? i : N_REQ-1-i);
  end
  assign any_o = |in_i;
endmodule

// File: rtl/event_encoder8_3.sv
// event_encoder8_3: registered 8-to-3 event encoder with pending capture and valid/ready output
module event_encoder8_3
  import event_encoder8_3_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] code_o,
  output logic [N_REQ-1:0]  pending_o,
  output logic              overflow_o
);
  state_e state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d, served, rem, enc_in;
  logic [CODE_W-1:0] code_q, code_d, pri_code;
  logic valid_q, valid_d, ovf_q, ovf_d, pri_any;
  assign served = (valid_q && ready_i) ? onehot(code_q) : '0;
  assign rem = pend_q & ~onehot(code_q);
  assign enc_in = (state_q == PRESENT) ? rem : pend_q;
  assign pend_d = (pend_q & ~served) | req_i;
  assign ovf_d = |(req_i & pend_q & ~served);
  pri_enc8_3 #(.PRIORITY_HIGH(PRIORITY_HIGH)) u_pri (
    .in_i  (enc_in),
    .code_o(pri_code),
    .any_o (pri_any)
  );
  // rem is built from registered pend only, keeping req_i off the code_o path
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    valid_d = valid_q;
    if (state_q == IDLE) begin
      if (pri_any) begin
        code_d = pri_code;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
    end else if (ready_i) begin
      code_d = pri_any ? pri_code : code_q;
      valid_d = pri_any;
      state_d = pri_any ? PRESENT : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      code_q <= code_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
    end
  assign valid_o = valid_q;
  assign code_o = code_q;
  assign pending_o = pend_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_event_encoder8_3.sv
// tb_event_encoder8_3: directed checks of the event encoder in both priority modes
module tb_event_encoder8_3;
  import event_encoder8_3_pkg::*;
  logic clk = 1'b0, rst_n;
  logic [7:0] req;
  logic ready;
  logic valid_h, ovf_h, valid_l, ovf_l;
  logic [2:0] code_h, code_l;
  logic [7:0] pend_h, pend_l;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  event_encoder8_3 #(.PRIORITY_HIGH(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .req_i(req), .ready_i(ready),
    .valid_o(valid_h), .code_o(code_h), .pending_o(pend_h), .overflow_o(ovf_h)
  );
  event_encoder8_3 #(.PRIORITY_HIGH(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req_i(req), .ready_i(ready),
    .valid_o(valid_l), .code_o(code_l), .pending_o(pend_l), .overflow_o(ovf_l)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int acc;
    logic [8:1] dec_got, dec_exp;
    rst_n = 1'b0; req = '0; ready = 1'b0;
    repeat (2) tick;
    chk("rst_valid", valid_h, 0);
    chk("rst_code", code_h, 0);
    chk("rst_pend", pend_h, 0);
    chk("rst_ovf", ovf_h, 0);
    rst_n = 1'b1;
    tick;
    ready = 1'b1; req = 8'h20;
    tick; req = '0;
    chk("single_pend1", pend_h, 8'h20);
    chk("single_valid1", valid_h, 0);
    tick;
    chk("single_valid2", valid_h, 1);
    chk("single_code2", code_h, 5);
    tick;
    chk("single_valid3", valid_h, 0);
    chk("single_pend3", pend_h, 0);
    req = 8'h85;
    tick; req = '0;
    tick;
    chk("burst_h0", code_h, 7); chk("burst_l0", code_l, 0); chk("burst_v0", valid_h, 1);
    tick;
    chk("burst_h1", code_h, 2); chk("burst_l1", code_l, 2); chk("burst_v1", valid_h, 1);
    tick;
    chk("burst_h2", code_h, 0); chk("burst_l2", code_l, 7); chk("burst_v2", valid_h, 1);
    tick;
    chk("burst_vh_end", valid_h, 0); chk("burst_vl_end", valid_l, 0);
    ready = 1'b0; req = 8'h08;
    tick; req = '0;
    tick;
    chk("bp_valid", valid_h, 1); chk("bp_code0", code_h, 3);
    req = 8'h40;
    tick; req = '0;
    chk("bp_code1", code_h, 3);
    tick;
    chk("bp_code2", code_h, 3); chk("bp_pend", pend_h, 8'h48);
    ready = 1'b1;
    tick;
    chk("bp_next", code_h, 6); chk("bp_next_v", valid_h, 1);
    tick;
    chk("bp_done", valid_h, 0);
    ready = 1'b0; req = 8'h10;
    tick; req = '0;
    chk("ovf_first", ovf_h, 0);
    tick;
    chk("ovf_code", code_h, 4);
    req = 8'h10;
    tick; req = '0;
    chk("ovf_pulse", ovf_h, 1);
    tick;
    chk("ovf_clear", ovf_h, 0);
    ready = 1'b1; acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (valid_h && code_h == 3'd4) acc++;
      tick;
    end
    chk("ovf_once", acc[7:0], 1);
    ready = 1'b0; req = 8'h10;
    tick; req = '0;
    tick;
    chk("coll_code", code_h, 4);
    ready = 1'b1; req = 8'h10;
    tick; req = '0;
    chk("coll_ovf", ovf_h, 0); chk("coll_pend", pend_h, 8'h10); chk("coll_gap", valid_h, 0);
    tick;
    chk("coll_again_v", valid_h, 1); chk("coll_again_c", code_h, 4);
    tick;
    chk("coll_end", valid_h, 0);
    ready = 1'b0; req = 8'hFF;
    tick; req = '0;
    tick;
    chk("mid_setup_v", valid_h, 1); chk("mid_setup_p", pend_h, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", valid_h, 0); chk("mid_code", code_h, 0);
    chk("mid_pend", pend_h, 0); chk("mid_ovf", ovf_h, 0);
    tick;
    rst_n = 1'b1; ready = 1'b1; req = 8'h01;
    tick; req = '0;
    chk("mid_after_p", pend_h, 8'h01);
    tick;
    chk("mid_after_v", valid_h, 1); chk("mid_after_c", code_h, 0);
    tick;
    for (int k = 0; k < 8; k++) begin
      req = 8'(1 << k);
      tick; req = '0;
      tick;
      dec_exp = '0; dec_exp[8-k] = 1'b1;
      dec_got = '0; dec_got[dec_out_idx(code_h)] = 1'b1;
      chk($sformatf("rt_code%0d", k), code_h, 8'(k));
      chk($sformatf("rt_dec%0d", k), dec_got, dec_exp);
      tick;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
